sram_fifo_ctrl_1w1r_32x128: RTL

- Single-clock FIFO controller for the 32-word x 128-bit 1W1R OpenRAM macro. It sits directly upstream of the macro, which is its storage.
- Upstream: valid/ready push. Downstream: valid/ready pop.
- Drives the macro's write port and read port, and captures read data.
- Hides the macro's registered-input, negedge-access, one-cycle read latency behind a 2-entry output skid buffer so streaming reaches 1 word/cycle.

---
 rtl/sram_fifo_ctrl_1w1r_32x128.sv | 93 +++++++++
 1 files changed

// File: rtl/sram_fifo_ctrl_1w1r_32x128.sv
// FIFO controller for a 32x128 1W1R SRAM macro. A 2-entry output buffer absorbs
// the macro's one-cycle read latency, so the FIFO can stream one word per cycle.
module sram_fifo_ctrl_1w1r_32x128 #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_WMASKS = 4,
  parameter int OB_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] SRAM_DEPTH = PTR_W'(1) << ADDR_WIDTH;

  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic                  rd_inflight_reg;
  logic [DATA_WIDTH-1:0] ob_mem [OB_DEPTH];
  logic                  ob_head_reg;
  logic [1:0]            ob_count_reg;

  logic [PTR_W-1:0] sram_used;
  logic             push;
  logic             pop;
  logic             rd_go;
  logic [2:0]       ob_pending;
  logic             ob_tail;

  assign sram_used = wr_ptr_reg - rd_ptr_reg;
  assign in_ready  = !rst && (sram_used != SRAM_DEPTH);
  assign push      = in_valid && in_ready;
  assign out_valid = !rst && (ob_count_reg != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = ob_mem[ob_head_reg];

  // Only issue a read if the word will have a buffer slot when it lands,
  // counting the read already in flight and crediting a same-cycle pop.
  assign ob_pending = {1'b0, ob_count_reg} + {2'b00, rd_inflight_reg};
  assign rd_go      = !rst && (sram_used != '0) && (ob_pending < (3'd2 + {2'b00, pop}));
  assign ob_tail    = ob_head_reg ^ ob_count_reg[0];

  assign count = rst ? '0
               : sram_used + PTR_W'(rd_inflight_reg) + PTR_W'(ob_count_reg);

  assign sram_csb0   = !push;
  assign sram_wmask0 = push ? '1 : '0;
  assign sram_addr0  = wr_ptr_reg[ADDR_WIDTH-1:0];
  assign sram_din0   = in_data;
  assign sram_csb1   = !rd_go;
  assign sram_addr1  = rd_ptr_reg[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      rd_inflight_reg <= 1'b0;
      ob_head_reg     <= 1'b0;
      ob_count_reg    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (rd_go) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      rd_inflight_reg <= rd_go;
      // Macro read data is only valid right at this edge.
      if (rd_inflight_reg) begin
        ob_mem[ob_tail] <= sram_dout1;
      end
      if (pop) begin
        ob_head_reg <= ~ob_head_reg;
      end
      ob_count_reg <= ob_count_reg + {1'b0, rd_inflight_reg} - {1'b0, pop};
    end
  end

endmodule
